// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : funct3 codes, FSM state type and access-size helpers for the LSU
// Rev 1.0
// ============================================================================
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   function automatic logic [3:0] size_mask(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   endfunction

   // Unsigned variants exist only for loads.
   function automatic logic is_legal(input logic we, input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_H, F3_W: is_legal = 1'b1;
         F3_BU, F3_HU:     is_legal = ~we;
         default:          is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3)
         F3_W:        is_split = (offset != 2'b00);
         F3_H, F3_HU: is_split = (offset == 2'b11);
         default:     is_split = 1'b0;
      endcase
   endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : byte-lane steering for stores and extraction/extension for loads
// Rev 1.0
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [7:0]  be,
   output logic [63:0] wdata_sh,
   output logic [31:0] rdata
);

   logic [31:0] w_sh;

   assign be       = {4'h0, size_mask(funct3)} << offset;
   assign wdata_sh = {32'h0, wdata} << {offset, 3'b000};
   assign w_sh     = 32'({hi, lo} >> {offset, 3'b000});

   always_comb begin
      rdata = 32'h0;
      case (funct3)
         F3_B:    rdata = {{24{w_sh[7]}}, w_sh[7:0]};
         F3_H:    rdata = {{16{w_sh[15]}}, w_sh[15:0]};
         F3_W:    rdata = w_sh;
         F3_BU:   rdata = {24'h0, w_sh[7:0]};
         F3_HU:   rdata = {16'h0, w_sh[15:0]};
         default: rdata = 32'h0;
      endcase
   end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// lsu : load/store unit, splits misaligned accesses and stalls the core
// Rev 1.0
// ============================================================================
module lsu
   import lsu_pkg::*;
#(
   parameter int SPLIT_EN = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        mem_en_o,
   output logic        mem_wen_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_din_o,
   input  logic [31:0] mem_dout_i,
   input  logic        mem_busy_i
);

   lsu_state_t  r_state;
   logic        r_we;
   logic        r_split;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic [31:0] r_lo;

   logic        w_idle;
   logic        w_legal;
   logic        w_split;
   logic        w_misalign_err;
   logic        w_complete;
   logic [2:0]  w_funct3;
   logic [1:0]  w_off;
   logic [31:0] w_wdata;
   logic [31:0] w_hi;
   logic [31:0] w_lo;
   logic [7:0]  w_be;
   logic [63:0] w_din;
   logic [31:0] w_rdata;

   // In IDLE the aligner sees the live request so FIRST's outputs can be registered directly.
   assign w_idle     = (r_state == IDLE);
   assign w_funct3   = w_idle ? funct3_i     : r_funct3;
   assign w_off      = w_idle ? addr_i[1:0]  : r_off;
   assign w_wdata    = w_idle ? wdata_i      : r_wdata;
   assign w_lo       = (r_state == SECOND) ? r_lo       : mem_dout_i;
   assign w_hi       = (r_state == SECOND) ? mem_dout_i : 32'h0;
   assign w_legal    = is_legal(we_i, funct3_i);
   assign w_split    = is_split(funct3_i, addr_i[1:0]);
   assign w_complete = mem_en_o & ~mem_busy_i;
   assign busy_o     = ~w_idle;

   generate
      if (SPLIT_EN != 0) begin : g_split
         assign w_misalign_err = 1'b0;
      end else begin : g_nosplit
         assign w_misalign_err = w_split;
      end
   endgenerate

   lsu_align u_align (
      .funct3   (w_funct3),
      .offset   (w_off),
      .wdata    (w_wdata),
      .hi       (w_hi),
      .lo       (w_lo),
      .be       (w_be),
      .wdata_sh (w_din),
      .rdata    (w_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_split    <= 1'b0;
         r_funct3   <= 3'b000;
         r_off      <= 2'b00;
         r_wdata    <= 32'h0;
         r_lo       <= 32'h0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         rdata_o    <= 32'h0;
         mem_en_o   <= 1'b0;
         mem_wen_o  <= 1'b0;
         mem_be_o   <= 4'h0;
         mem_addr_o <= 32'h0;
         mem_din_o  <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_i) begin
                  r_we     <= we_i;
                  r_funct3 <= funct3_i;
                  r_off    <= addr_i[1:0];
                  r_wdata  <= wdata_i;
                  r_split  <= w_split;
                  if (!w_legal || w_misalign_err) begin
                     r_state <= RESP;
                     done_o  <= 1'b1;
                     err_o   <= 1'b1;
                     rdata_o <= 32'h0;
                  end else begin
                     r_state    <= FIRST;
                     mem_en_o   <= 1'b1;
                     mem_wen_o  <= we_i;
                     mem_be_o   <= w_be[3:0];
                     mem_addr_o <= {addr_i[31:2], 2'b00};
                     mem_din_o  <= w_din[31:0];
                  end
               end
            end
            FIRST: begin
               if (w_complete) begin
                  r_lo <= mem_dout_i;
                  if (r_split) begin
                     r_state    <= SECOND;
                     mem_addr_o <= mem_addr_o + 32'd4;
                     mem_be_o   <= w_be[7:4];
                     mem_din_o  <= w_din[63:32];
                  end else begin
                     r_state    <= RESP;
                     done_o     <= 1'b1;
                     err_o      <= 1'b0;
                     rdata_o    <= r_we ? 32'h0 : w_rdata;
                     mem_en_o   <= 1'b0;
                     mem_wen_o  <= 1'b0;
                     mem_be_o   <= 4'h0;
                     mem_addr_o <= 32'h0;
                     mem_din_o  <= 32'h0;
                  end
               end
            end
            SECOND: begin
               if (w_complete) begin
                  r_state    <= RESP;
                  done_o     <= 1'b1;
                  err_o      <= 1'b0;
                  rdata_o    <= r_we ? 32'h0 : w_rdata;
                  mem_en_o   <= 1'b0;
                  mem_wen_o  <= 1'b0;
                  mem_be_o   <= 4'h0;
                  mem_addr_o <= 32'h0;
                  mem_din_o  <= 32'h0;
               end
            end
            RESP: begin
               r_state <= IDLE;
               done_o  <= 1'b0;
               err_o   <= 1'b0;
               rdata_o <= 32'h0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule : lsu
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit between the core's memory-stage signals (funct3, address, store data) and the word-wide data memory port (en/wen/din/addr/dout/busy).
- Converts byte, half and word accesses into word-aligned accesses with byte enables, and performs load extraction with sign or zero extension.
- Splits misaligned accesses into two sequential memory accesses.
- Stalls the core through a busy/done handshake while the memory back-pressures via its busy signal.

Parameters:
- SPLIT_EN, 1: 1 = misaligned accesses are split into two accesses; 0 = misaligned accesses are rejected with err_o and make no memory access.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_i  in  1  single-cycle request pulse from the core; sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I load/store funct3
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-justified
- busy_o  out  1  high whenever state is not IDLE; the core stalls on it
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; 1 = illegal funct3, or misaligned with SPLIT_EN=0
- rdata_o  out  32  extended load result; valid with done_o, 0 otherwise
- mem_en_o  out  1  memory access enable
- mem_wen_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address; bits [1:0] always 0
- mem_din_o  out  32  lane-shifted write data
- mem_dout_i  in  32  memory read data; valid in the completing cycle
- mem_busy_i  in  1  memory not ready

Behaviour:
- Reset (asynchronous, any state): state=IDLE; every output 0.
- Request latch: on req_i in IDLE, latch we, funct3, addr and wdata; these latched values drive all later cycles. req_i outside IDLE is ignored.
- Legal funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU (loads only).
- Illegal: any other funct3, or a store with funct3[2]=1. Result: IDLE -> RESP with err_o=1 and no memory access.
- Size mask: m = 0001 / 0011 / 1111 for byte / half / word. Offset o = addr[1:0].
- Split condition: word with o!=0, or half with o=3.
- States and transitions:
  - IDLE: on req_i -> FIRST, or -> RESP if illegal.
  - FIRST: mem_en_o=1, mem_addr_o={addr[31:2],2'b00}, mem_be_o=(m<<o)[3:0], mem_din_o=(wdata<<8o)[31:0]. On a complete cycle: -> SECOND if split, else -> RESP.
  - SECOND: mem_addr_o = first address + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000); mem_be_o=(m<<o)[7:4]; mem_din_o=(wdata<<8o)[63:32]. On a complete cycle -> RESP.
  - RESP: done_o=1 -> IDLE.
- A complete cycle is mem_en_o=1 and mem_busy_i=0.
- mem_en_o, mem_addr_o, mem_be_o, mem_wen_o and mem_din_o are held stable while mem_busy_i=1. They are driven 0 in IDLE and RESP.
- mem_wen_o = latched we during FIRST and SECOND.
- Loads:
  - On the FIRST complete cycle, capture mem_dout_i into lo; on the SECOND complete cycle, capture into hi (hi=0 if no split).
  - Result = ({hi,lo} >> 8o), truncated to the access size, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Presented on rdata_o in RESP.
- Stores: rdata_o=0.
- Latency with zero-wait memory: req at cycle N -> done_o at N+2 (aligned) or N+3 (split). Each busy cycle adds 1. An illegal request gives done_o at N+1.
- Misaligned with SPLIT_EN=0: IDLE -> RESP with err_o=1 and no memory access.
- Reset asserted mid-access drops mem_en_o immediately. The memory discards any partial access; a store already completed in FIRST is not rolled back.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, FIRST, SECOND, RESP}.
  - Function size_mask(funct3).
- Sub-module lsu_align (combinational): from funct3, offset and wdata, produces the 8-bit shifted enables and 64-bit shifted store data. It also produces the extended load result from {hi,lo}.
- lsu holds the FSM and the registers.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, zero-wait memory -> one access: addr 0x100, be 1111, din 0xDEADBEEF, wen=1; done_o at N+2, err_o=0.
- LB addr 0x203, mem word 0x80112233 -> be 1000; rdata_o 0xFFFFFF80. LBU at the same address -> 0x00000080.
- LW addr 0x102, memory 0x100=0xAABBCCDD and 0x104=0x11223344:
  - first access be 1100 at 0x100; second access be 0011 at 0x104.
  - rdata_o 0x3344AABB; done_o at N+3.
- SH addr 0xFFFFFFFF, data 0x1234:
  - first access be 1000 at 0xFFFFFFFC, din 0x34000000.
  - second access be 0001 at 0x00000000, din 0x00000012.
- mem_busy_i held high 3 cycles during FIRST -> mem outputs stable throughout; done_o at N+5. Also: funct3=011 -> err_o=1 at N+1 with no mem_en_o.
- rst_n_i asserted in SECOND -> all outputs 0 the same cycle. A following LW at 0x0 completes normally.
